// File: rtl/ram_op_master.sv
// Bus initiator for the 1024x10 program/data RAM: fetches a descriptor
// pointer, reads two operands, runs add/sub/shift-add multiply and writes back.
module ram_op_master #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH_PTR, S_READ_A, S_READ_B, S_EXEC, S_WRITE, S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [ADDR_W-1:0]   p_q, p_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [CNT_W-1:0]    i_q, i_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_we_q, mem_we_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic [DATA_W-1:0]   partial;

  always_comb begin
    // NOTE: every signal gets a default up front so no path leaves it unassigned (no latches).
    state_d  = state_q;
    op_d     = op_q;
    p_d      = p_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    i_d      = i_q;
    result_d = result_q;
    partial  = b_q[i_q] ? (a_q << i_q) : '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          state_d = S_FETCH_PTR;
        end
      end
      S_FETCH_PTR: begin
        p_d     = ADDR_W'(mem_rdata);
        state_d = S_READ_A;
      end
      S_READ_A: begin
        a_d     = mem_rdata;
        state_d = S_READ_B;
      end
      S_READ_B: begin
        b_d     = mem_rdata;
        acc_d   = '0;
        i_d     = '0;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (op_q == OP_MUL) begin
          acc_d = acc_q + partial;
          i_d   = i_q + CNT_W'(1);
          if (i_q == CNT_W'(DATA_W - 1)) state_d = S_WRITE;
        end else begin
          acc_d   = (op_q == OP_SUB) ? (a_q - b_q) : (a_q + b_q);
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        result_d = acc_q;
        state_d  = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    unique case (state_d)
      S_READ_A: mem_addr_d = p_d;
      S_READ_B: mem_addr_d = p_q + ADDR_W'(1);
      S_WRITE:  mem_addr_d = p_q + ADDR_W'(2);
      default:  mem_addr_d = '0;
    endcase
    mem_we_d    = (state_d == S_WRITE);
    mem_wdata_d = (state_d == S_WRITE) ? acc_d : mem_wdata_q;
    busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d      = (state_d == S_DONE);
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      p_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      i_q         <= '0;
      result_q    <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      p_q         <= p_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      i_q         <= i_d;
      result_q    <= result_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;

endmodule

// File: tb/tb_ram_op_master.sv
// Self-checking bench for ram_op_master: RAM model plus arithmetic reference.
module tb_ram_op_master;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] op_i;
  logic [9:0] mem_rdata, mem_addr, mem_wdata, result;
  logic       mem_we, busy, done;

  logic [9:0] ram [0:1023];
  logic [9:0] addr_log [0:40];
  int         vectors = 0;
  int         miscompares = 0;
  int         lat, we_cnt;
  logic [9:0] we_addr, we_data;

  ram_op_master dut (
    .clk(clk), .reset(reset), .start(start), .op(op_i),
    .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  assign mem_rdata = ram[mem_addr];
  always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;

  function automatic logic [9:0] ref_op(input logic [1:0] o, input int a, input int b);
    if (o == 2'b10) return 10'((a * b) % 1024);
    if (o == 2'b01) return 10'((a - b + 1024) % 1024);
    return 10'((a + b) % 1024);
  endfunction

  task automatic preload(input int p, input int a, input int b, input int r);
    ram[0] = 10'(p);
    ram[p] = 10'(a);
    ram[(p + 1) % 1024] = 10'(b);
    ram[(p + 2) % 1024] = 10'(r);
  endtask

  // Runs one transaction, logging addresses, writes and start-to-done latency.
  task automatic run_txn(input logic [1:0] o);
    @(negedge clk);
    start = 1'b1;
    op_i  = o;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; we_cnt = 0; we_addr = '0; we_data = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      addr_log[c] = mem_addr;
      if (mem_we) begin we_cnt++; we_addr = mem_addr; we_data = mem_wdata; end
      if (done) begin lat = c; break; end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op_i = 2'b00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if ({busy, done, mem_we, mem_addr, mem_wdata, result} !== 33'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got busy=%b done=%b we=%b addr=%0d wdata=%0d result=%0d, expected all 0",
               busy, done, mem_we, mem_addr, mem_wdata, result);
    end
  endtask

  task automatic test_add();
    preload(10, 5, 3, 0);
    run_txn(2'b00);
    vectors++;
    if (addr_log[1] !== 10'd0 || addr_log[2] !== 10'd10 || addr_log[3] !== 10'd11) begin
      miscompares++;
      $display("FAIL add_read_addrs: got %0d,%0d,%0d expected 0,10,11", addr_log[1], addr_log[2], addr_log[3]);
    end
    vectors++;
    if (we_cnt !== 1 || we_addr !== 10'd12 || we_data !== 10'd8) begin
      miscompares++;
      $display("FAIL add_write: got cnt=%0d addr=%0d data=%0d expected 1,12,8", we_cnt, we_addr, we_data);
    end
    vectors++;
    if (lat !== 6) begin miscompares++; $display("FAIL add_latency: got %0d expected 6", lat); end
    vectors++;
    if (result !== 10'd8 || ram[12] !== 10'd8) begin
      miscompares++;
      $display("FAIL add_result: got result=%0d ram=%0d expected 8", result, ram[12]);
    end
  endtask

  task automatic test_sub_mul();
    preload(10, 5, 3, 0);
    run_txn(2'b01);
    vectors++;
    if (ram[12] !== 10'd2 || result !== 10'd2) begin
      miscompares++;
      $display("FAIL sub_result: got ram=%0d result=%0d expected 2", ram[12], result);
    end
    preload(10, 5, 3, 0);
    run_txn(2'b10);
    vectors++;
    if (ram[12] !== 10'd15 || result !== 10'd15) begin
      miscompares++;
      $display("FAIL mul_result: got ram=%0d result=%0d expected 15", ram[12], result);
    end
    vectors++;
    if (lat !== 15 || we_cnt !== 1) begin
      miscompares++;
      $display("FAIL mul_timing: got latency=%0d we_cycles=%0d expected 15,1", lat, we_cnt);
    end
  endtask

  task automatic test_wrap_arith();
    logic [1:0] ops [3] = '{2'b01, 2'b10, 2'b00};
    int av [3] = '{3, 40, 1023};
    int bv [3] = '{5, 40, 1};
    logic [9:0] exp_v [3] = '{10'h3FE, 10'd576, 10'd0};
    for (int k = 0; k < 3; k++) begin
      preload(10, av[k], bv[k], 10'h2AA);
      run_txn(ops[k]);
      vectors++;
      if (ram[12] !== exp_v[k]) begin
        miscompares++;
        $display("FAIL arith_wrap_%0d: got %0d expected %0d", k, ram[12], exp_v[k]);
      end
    end
  endtask

  task automatic test_ptr_wrap();
    ram[0] = 10'd1023; ram[1023] = 10'd7; ram[1] = 10'd99;
    run_txn(2'b00);
    vectors++;
    if (addr_log[3] !== 10'd0 || we_addr !== 10'd1) begin
      miscompares++;
      $display("FAIL ptr_wrap_addrs: got readB=%0d write=%0d expected 0,1", addr_log[3], we_addr);
    end
    vectors++;
    if (ram[1] !== 10'd6) begin miscompares++; $display("FAIL ptr_wrap_data: got %0d expected 6", ram[1]); end
  endtask

  task automatic test_reset_mid();
    int saw_we = 0;
    preload(10, 5, 3, 10'h155);
    @(negedge clk);
    start = 1'b1; op_i = 2'b10;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_we) saw_we++;
    end
    reset = 1'b1;
    #1;
    vectors++;
    if ({busy, done, mem_we, mem_addr, mem_wdata, result} !== 33'd0) begin
      miscompares++;
      $display("FAIL reset_mid_outputs: got busy=%b done=%b we=%b addr=%0d wdata=%0d result=%0d, expected all 0",
               busy, done, mem_we, mem_addr, mem_wdata, result);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    vectors++;
    if (saw_we !== 0 || ram[12] !== 10'h155) begin
      miscompares++;
      $display("FAIL reset_mid_nowrite: got we_cycles=%0d ram=%0d expected 0,%0d", saw_we, ram[12], 10'h155);
    end
    run_txn(2'b10);
    vectors++;
    if (ram[12] !== 10'd15 || lat !== 15) begin
      miscompares++;
      $display("FAIL reset_mid_rerun: got ram=%0d latency=%0d expected 15,15", ram[12], lat);
    end
  endtask

  task automatic test_back_to_back();
    preload(10, 5, 3, 0);
    @(negedge clk);
    start = 1'b1; op_i = 2'b00;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 6) begin
        vectors++;
        if (done !== 1'b1 || result !== 10'd8) begin
          miscompares++;
          $display("FAIL b2b_first: got done=%b result=%0d expected 1,8", done, result);
        end
      end
      if (c == 7) begin
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_idle_gap: got busy=%b done=%b expected 0,0", busy, done);
        end
      end
      if (c == 8) begin
        vectors++;
        if (busy !== 1'b1 || mem_addr !== 10'd0) begin
          miscompares++;
          $display("FAIL b2b_relaunch: got busy=%b addr=%0d expected 1,0", busy, mem_addr);
        end
      end
      if (c == 13) begin
        vectors++;
        if (done !== 1'b1 || result !== 10'd2) begin
          miscompares++;
          $display("FAIL b2b_second: got done=%b result=%0d expected 1,2", done, result);
        end
      end
      // Stray mul request during READ_B, then a held sub request from WRITE.
      if (c == 3) begin start = 1'b1; op_i = 2'b10; end
      if (c == 4) start = 1'b0;
      if (c == 5) begin start = 1'b1; op_i = 2'b01; end
      if (c == 8) start = 1'b0;
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      int p, a, b, wa;
      logic [1:0] o;
      logic [9:0] exp_r;
      p = $urandom_range(0, 1023);
      o = 2'($urandom_range(0, 3));
      ram[0] = 10'(p);
      if (p != 0) ram[p] = 10'($urandom_range(0, 1023));
      if ((p + 1) % 1024 != 0) ram[(p + 1) % 1024] = 10'($urandom_range(0, 1023));
      a = int'(ram[p]);
      b = int'(ram[(p + 1) % 1024]);
      wa = (p + 2) % 1024;
      exp_r = ref_op(o, a, b);
      run_txn(o);
      vectors++;
      if (result !== exp_r || ram[wa] !== exp_r || lat !== ((o == 2'b10) ? 15 : 6)) begin
        miscompares++;
        $display("FAIL random_%0d: op=%0d P=%0d A=%0d B=%0d got result=%0d ram=%0d latency=%0d expected %0d",
                 n, o, p, a, b, result, ram[wa], lat, exp_r);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 1024; k++) ram[k] = '0;
    test_reset();
    test_add();
    test_sub_mul();
    test_wrap_arith();
    test_ptr_wrap();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
